// File: rtl/mux_compare_monitor.sv
// mux_compare_monitor: compares the assign-style (c_in) and if-style (d_in)
// outputs of a 2:1 selector over a programmed run of sample pairs.
// Ports:
//   clk, rst          - clock, async active-high reset
//   start/num_samples - begin a run of num_samples pairs (sampled in IDLE)
//   in_valid/in_ready - pair handshake; a pair is taken when both are high
//   c_in, d_in        - the two selector outputs under comparison
//   busy, done        - run in progress / one-cycle end-of-run pulse
//   pass              - last completed run had no mismatches
//   mismatch_count    - saturating mismatch count of current/last run
//   first_idx/c/d     - index and values of the first mismatching pair
module mux_compare_monitor #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] c_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [CNT_W-1:0] first_idx,
    output logic [WIDTH-1:0] first_c,
    output logic [WIDTH-1:0] first_d
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

    state_t           state_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] fidx_q;
    logic [WIDTH-1:0] fc_q;
    logic [WIDTH-1:0] fd_q;
    logic             found_q;
    logic             done_q;
    logic             pass_q;
    logic             accept;
    logic             mis;
    logic             last;

    assign in_ready = (state_q == RUN);
    assign busy     = (state_q == RUN);
    assign accept   = in_valid && (state_q == RUN);

    // Case inequality so that an X/Z bit facing a differing bit is flagged
    // in 4-state simulation; it collapses to != in hardware.
    assign mis = (c_in !== d_in);

    // Count including the pair accepted this cycle, saturating at all-ones.
    assign cnt_d = (accept && mis && (cnt_q != MAX)) ? cnt_q + ONE : cnt_q;

    assign last = accept && (idx_q == len_q - ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            fidx_q  <= '0;
            fc_q    <= '0;
            fd_q    <= '0;
            found_q <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        len_q   <= num_samples;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        fidx_q  <= '0;
                        fc_q    <= '0;
                        fd_q    <= '0;
                        found_q <= 1'b0;
                        if (num_samples == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            pass_q  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        idx_q <= idx_q + ONE;
                        cnt_q <= cnt_d;
                        if (mis && !found_q) begin
                            found_q <= 1'b1;
                            fidx_q  <= idx_q;
                            fc_q    <= c_in;
                            fd_q    <= d_in;
                        end
                        if (last) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            pass_q  <= (cnt_d == '0);
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign done           = done_q;
    assign pass           = pass_q;
    assign mismatch_count = cnt_q;
    assign first_idx      = fidx_q;
    assign first_c        = fc_q;
    assign first_d        = fd_q;

endmodule

// File: tb/tb_mux_compare_monitor.sv
// Directed bench for mux_compare_monitor with CNT_W=4, WIDTH=2.
// Inputs change and outputs are checked 1 time unit after each rising edge.
module tb_mux_compare_monitor;

    localparam int WIDTH = 2;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] c_in;
    logic [WIDTH-1:0] d_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] mismatch_count;
    logic [CNT_W-1:0] first_idx;
    logic [WIDTH-1:0] first_c;
    logic [WIDTH-1:0] first_d;

    int errors = 0;
    int checks = 0;

    mux_compare_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .num_samples    (num_samples),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .c_in           (c_in),
        .d_in           (d_in),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .mismatch_count (mismatch_count),
        .first_idx      (first_idx),
        .first_c        (first_c),
        .first_d        (first_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [CNT_W-1:0] n);
        start       = 1'b1;
        num_samples = n;
        tick();
        start = 1'b0;
    endtask

    task automatic pair(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
        c_in     = c;
        d_in     = d;
        in_valid = 1'b1;
        tick();
    endtask

    task automatic stall();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic chk_results(input string tag, input logic [CNT_W-1:0] cnt,
                               input logic [CNT_W-1:0] fi,
                               input logic [WIDTH-1:0] fc,
                               input logic [WIDTH-1:0] fd,
                               input logic ps);
        chk({tag, ".count"}, 32'(mismatch_count), 32'(cnt));
        chk({tag, ".first_idx"}, 32'(first_idx), 32'(fi));
        chk({tag, ".first_c"}, 32'(first_c), 32'(fc));
        chk({tag, ".first_d"}, 32'(first_d), 32'(fd));
        chk({tag, ".pass"}, 32'(pass), 32'(ps));
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        num_samples = '0;
        in_valid    = 1'b0;
        c_in        = '0;
        d_in        = '0;
        tick();
        tick();
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk_results("rst", 4'd0, 4'd0, 2'd0, 2'd0, 1'b0);
        rst = 1'b0;
        tick();

        // Four matching pairs.
        go(4'd4);
        chk("t1.busy", 32'(busy), 32'd1);
        chk("t1.in_ready", 32'(in_ready), 32'd1);
        pair(2'd0, 2'd0);
        pair(2'd1, 2'd1);
        pair(2'd2, 2'd2);
        chk("t1.done_early", 32'(done), 32'd0);
        pair(2'd3, 2'd3);
        in_valid = 1'b0;
        chk("t1.done", 32'(done), 32'd1);
        chk("t1.busy_done", 32'(busy), 32'd0);
        chk_results("t1", 4'd0, 4'd0, 2'd0, 2'd0, 1'b1);
        tick();
        chk("t1.done_low", 32'(done), 32'd0);

        // Mismatches at pairs 2 and 4.
        go(4'd5);
        pair(2'd0, 2'd0);
        pair(2'd3, 2'd3);
        pair(2'b01, 2'b10);
        chk("t2.count_mid", 32'(mismatch_count), 32'd1);
        pair(2'd2, 2'd2);
        pair(2'b11, 2'b00);
        in_valid = 1'b0;
        chk("t2.done", 32'(done), 32'd1);
        chk_results("t2", 4'd2, 4'd2, 2'b01, 2'b10, 1'b0);
        tick();
        tick();
        chk("t2.hold_count", 32'(mismatch_count), 32'd2);
        chk("t2.hold_pass", 32'(pass), 32'd0);

        // Unknown select bit upstream, paired with a differing known bit.
        go(4'd1);
        pair(2'bx0, 2'b01);
        in_valid = 1'b0;
        chk("t3.done", 32'(done), 32'd1);
        chk("t3.count", 32'(mismatch_count), 32'd1);
        chk("t3.first_idx", 32'(first_idx), 32'd0);
        chk("t3.pass", 32'(pass), 32'd0);
        tick();

        // Stalled stream with start pulses during RUN.
        go(4'd3);
        pair(2'd1, 2'd1);
        start = 1'b1;
        stall();
        chk("t4.stall1_busy", 32'(busy), 32'd1);
        start = 1'b0;
        stall();
        chk("t4.stall2_done", 32'(done), 32'd0);
        pair(2'd2, 2'd2);
        start = 1'b1;
        stall();
        start = 1'b0;
        chk("t4.stall3_busy", 32'(busy), 32'd1);
        chk("t4.stall3_done", 32'(done), 32'd0);
        pair(2'd3, 2'd3);
        in_valid = 1'b0;
        chk("t4.done", 32'(done), 32'd1);
        chk_results("t4", 4'd0, 4'd0, 2'd0, 2'd0, 1'b1);
        tick();
        chk("t4.idle_busy", 32'(busy), 32'd0);
        chk("t4.idle_done", 32'(done), 32'd0);

        // Every pair mismatches: count reaches the 4-bit maximum.
        go(4'd15);
        for (int i = 0; i < 15; i++) pair(2'd0, 2'd3);
        in_valid = 1'b0;
        chk("t5.done", 32'(done), 32'd1);
        chk_results("t5", 4'd15, 4'd0, 2'd0, 2'd3, 1'b0);
        tick();

        // Zero-length run.
        go(4'd0);
        chk("t5z.done", 32'(done), 32'd1);
        chk("t5z.busy", 32'(busy), 32'd0);
        chk_results("t5z", 4'd0, 4'd0, 2'd0, 2'd0, 1'b1);
        tick();
        chk("t5z.done_low", 32'(done), 32'd0);

        // Reset in the middle of a run.
        go(4'd6);
        pair(2'd0, 2'd0);
        pair(2'd1, 2'd2);
        chk("t6.count_mid", 32'(mismatch_count), 32'd1);
        chk("t6.first_idx_mid", 32'(first_idx), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6.rst_busy", 32'(busy), 32'd0);
        chk("t6.rst_in_ready", 32'(in_ready), 32'd0);
        chk("t6.rst_done", 32'(done), 32'd0);
        chk_results("t6.rst", 4'd0, 4'd0, 2'd0, 2'd0, 1'b0);
        tick();
        tick();
        chk("t6.rst_done2", 32'(done), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("t6.after_busy", 32'(busy), 32'd0);
        chk("t6.after_done", 32'(done), 32'd0);

        // Normal run after reset.
        go(4'd2);
        pair(2'd2, 2'd2);
        pair(2'd1, 2'd1);
        in_valid = 1'b0;
        chk("t7.done", 32'(done), 32'd1);
        chk_results("t7", 4'd0, 4'd0, 2'd0, 2'd0, 1'b1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
